// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - Shared AES constants, FSM encodings and round-transform helpers
// Contents:
//   AES128_ROUNDS / AES256_ROUNDS   round counts selected by key length
//   AES_128_BIT_KEY / AES_256_BIT_KEY keylen encodings
//   enc_state_e                      encipher control FSM states
//   gm2, gm3, mixw, mixcolumns, shiftrows, addroundkey
package aes_pkg;

  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;
  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } enc_state_e;

  // Multiply by {02} in GF(2^8); the conditional xor reduces modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] op);
    return gm2(op) ^ op;
  endfunction

  // One column of MixColumns; byte 0 (row 0) lives in bits [31:24].
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] mb0, mb1, mb2, mb3;
    b0  = w[31:24];
    b1  = w[23:16];
    b2  = w[15:8];
    b3  = w[7:0];
    mb0 = gm2(b0) ^ gm3(b1) ^ b2 ^ b3;
    mb1 = b0 ^ gm2(b1) ^ gm3(b2) ^ b3;
    mb2 = b0 ^ b1 ^ gm2(b2) ^ gm3(b3);
    mb3 = gm3(b0) ^ b1 ^ b2 ^ gm2(b3);
    return {mb0, mb1, mb2, mb3};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] data);
    return {mixw(data[127:96]), mixw(data[95:64]), mixw(data[63:32]), mixw(data[31:0])};
  endfunction

  // Words are columns, so row r of column i is taken from column i+r.
  function automatic logic [127:0] shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] ws0, ws1, ws2, ws3;
    w0  = data[127:96];
    w1  = data[95:64];
    w2  = data[63:32];
    w3  = data[31:0];
    ws0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
    ws1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
    ws2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
    ws3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    return {ws0, ws1, ws2, ws3};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] data,
                                               input logic [127:0] rkey);
    return data ^ rkey;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - Combinational forward AES S-box on a 32-bit word
// Ports:
//   sboxw      in  32  word whose four bytes are substituted
//   new_sboxw  out 32  substituted word, byte order preserved
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  // Entry for byte value b occupies bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // For an 11-bit index, 2047 - 8*b is simply the bitwise inverse of {b, 000}.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] msb;
    msb = ~{b, 3'b000};
    return SBOX_TABLE[msb -: 8];
  endfunction

  assign new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                      sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - Iterative AES-128/256 forward cipher round engine
// Build option: AES_ENC_PARALLEL_SBOX_EN selects four S-boxes (one SubBytes cycle)
//   instead of one shared word S-box (four SubBytes cycles).
// Ports:
//   clk        in   1   clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   next       in   1   start request, honoured only in IDLE
//   keylen     in   1   0 = AES-128, 1 = AES-256, latched on start
//   round      out  4   round-key index into the key memory
//   round_key  in 128   key-memory data for round, same cycle
//   block      in 128   plaintext, sampled in the INIT cycle
//   new_block  out 128  working state / ciphertext, w0 in [127:96]
//   ready      out  1   idle with result valid
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  enc_state_e  state_q, state_d;
  logic [31:0] block_w_q [4];
  logic [31:0] block_w_d [4];
  logic [1:0]  sword_ctr_q, sword_ctr_d;
  logic [3:0]  round_ctr_q, round_ctr_d;
  logic        keylen_q, keylen_d;
  logic        ready_q, ready_d;

  logic [3:0]   num_rounds;
  logic [127:0] old_block;
  logic [127:0] round_block;
  logic         load_block;

  assign num_rounds = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign old_block  = {block_w_q[0], block_w_q[1], block_w_q[2], block_w_q[3]};

`ifdef AES_ENC_PARALLEL_SBOX_EN
  logic [31:0] sbox_out [4];

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .sboxw     (block_w_q[i]),
      .new_sboxw (sbox_out[i])
    );
  end
`else
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;

  // One S-box is time-shared across the four words, selected by sword_ctr.
  assign sbox_in = block_w_q[sword_ctr_q];

  aes_sbox u_sbox (
    .sboxw     (sbox_in),
    .new_sboxw (sbox_out)
  );
`endif

  always_comb begin
    state_d     = state_q;
    sword_ctr_d = sword_ctr_q;
    round_ctr_d = round_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    for (int i = 0; i < 4; i++) begin
      block_w_d[i] = block_w_q[i];
    end
    round_block = '0;
    load_block  = 1'b0;

    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          round_ctr_d = 4'd0;
          keylen_d    = keylen;
          ready_d     = 1'b0;
          state_d     = CTRL_INIT;
        end
      end

      CTRL_INIT: begin
        round_block = addroundkey(block, round_key);
        load_block  = 1'b1;
        round_ctr_d = 4'd1;
        sword_ctr_d = 2'd0;
        state_d     = CTRL_SBOX;
      end

      CTRL_SBOX: begin
`ifdef AES_ENC_PARALLEL_SBOX_EN
        for (int i = 0; i < 4; i++) begin
          block_w_d[i] = sbox_out[i];
        end
        state_d = CTRL_MAIN;
`else
        block_w_d[sword_ctr_q] = sbox_out;
        sword_ctr_d            = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) begin
          state_d = CTRL_MAIN;
        end
`endif
      end

      CTRL_MAIN: begin
        load_block = 1'b1;
        if (round_ctr_q < num_rounds) begin
          round_block = addroundkey(mixcolumns(shiftrows(old_block)), round_key);
          round_ctr_d = round_ctr_q + 4'd1;
          sword_ctr_d = 2'd0;
          state_d     = CTRL_SBOX;
        end else begin
          // Final round: no MixColumns; round stays on the last key index.
          round_block = addroundkey(shiftrows(old_block), round_key);
          ready_d     = 1'b1;
          state_d     = CTRL_IDLE;
        end
      end

      default: begin
        state_d = CTRL_IDLE;
      end
    endcase

    if (load_block) begin
      block_w_d[0] = round_block[127:96];
      block_w_d[1] = round_block[95:64];
      block_w_d[2] = round_block[63:32];
      block_w_d[3] = round_block[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CTRL_IDLE;
      sword_ctr_q <= 2'd0;
      round_ctr_q <= 4'd0;
      keylen_q    <= AES_128_BIT_KEY;
      ready_q     <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        block_w_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      sword_ctr_q <= sword_ctr_d;
      round_ctr_q <= round_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      for (int i = 0; i < 4; i++) begin
        block_w_q[i] <= block_w_d[i];
      end
    end
  end

  assign round     = round_ctr_q;
  assign new_block = old_block;
  assign ready     = ready_q;

endmodule
